// File: rtl/dec_queue.sv
// RV32IM decoder feeding an in-order queue of decoded packets, LANES pushed/popped per cycle.
// Define DEC_QUEUE_ILLEGAL_EN to store and report a per-entry illegal-instruction flag.
package dec_queue_pkg;
   typedef enum logic [5:0] {
      ALU_OP_NOP, ALU_OP_LUI, ALU_OP_AUIPC, ALU_OP_JAL, ALU_OP_JALR,
      ALU_OP_BEQ, ALU_OP_BNE, ALU_OP_BLT, ALU_OP_BGE, ALU_OP_BLTU, ALU_OP_BGEU,
      ALU_OP_LB, ALU_OP_LH, ALU_OP_LW, ALU_OP_LBU, ALU_OP_LHU,
      ALU_OP_SB, ALU_OP_SH, ALU_OP_SW,
      ALU_OP_ADDI, ALU_OP_SLTI, ALU_OP_SLTIU, ALU_OP_XORI, ALU_OP_ORI, ALU_OP_ANDI,
      ALU_OP_SLLI, ALU_OP_SRLI, ALU_OP_SRAI,
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_XOR,
      ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND,
      ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU,
      ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU,
      ALU_OP_FENCE, ALU_OP_ECALL, ALU_OP_EBREAK
   } alu_op_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } rv32_if_packet_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm32;
      logic [4:0]  rs1_sel;
      logic [4:0]  rs2_sel;
      logic [4:0]  rd_sel;
      alu_op_t     alu_op;
   } rv32_instr_packet_t;
endpackage

module dec_queue
   import dec_queue_pkg::*;
#(
   parameter int LANES = 2,
   parameter int DEPTH = 8
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst,
   input  logic                                          i_flush,
   input  logic [LANES-1:0]                              i_in_valid,
   input  logic [LANES*$bits(rv32_if_packet_t)-1:0]      i_in_packet,
   output logic                                          o_in_ready,
   output logic [LANES-1:0]                              o_out_valid,
   output logic [LANES*$bits(rv32_instr_packet_t)-1:0]   o_out_packet,
   output logic [LANES-1:0]                              o_out_illegal,
   input  logic [LANES-1:0]                              i_out_ready
);
   localparam int PW  = $clog2(DEPTH);
   localparam int IFW = $bits(rv32_if_packet_t);
   localparam int PKW = $bits(rv32_instr_packet_t);

   // Every legal encoding assigns a real op, so illegal is exactly "op stayed NOP".
   function automatic void f_decode(input logic [31:0] ins, input logic [31:0] pc,
                                    output rv32_instr_packet_t pkt, output logic ill);
      logic [31:0] imm;
      logic        use1, use2, used;
      alu_op_t     op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      op = ALU_OP_NOP; imm = '0; use1 = 1'b0; use2 = 1'b0; used = 1'b0;
      case (ins[6:0])
         7'b0110111: begin op = ALU_OP_LUI;   imm = {ins[31:12], 12'b0}; used = 1'b1; end
         7'b0010111: begin op = ALU_OP_AUIPC; imm = {ins[31:12], 12'b0}; used = 1'b1; end
         7'b1101111: begin
            op = ALU_OP_JAL; used = 1'b1;
            imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         end
         7'b1100111: begin
            imm = {{20{ins[31]}}, ins[31:20]}; use1 = 1'b1; used = 1'b1;
            if (f3 == 3'd0) op = ALU_OP_JALR;
         end
         7'b1100011: begin
            imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            use1 = 1'b1; use2 = 1'b1;
            case (f3)
               3'd0: op = ALU_OP_BEQ;   3'd1: op = ALU_OP_BNE;
               3'd4: op = ALU_OP_BLT;   3'd5: op = ALU_OP_BGE;
               3'd6: op = ALU_OP_BLTU;  3'd7: op = ALU_OP_BGEU;
               default: op = ALU_OP_NOP;
            endcase
         end
         7'b0000011: begin
            imm = {{20{ins[31]}}, ins[31:20]}; use1 = 1'b1; used = 1'b1;
            case (f3)
               3'd0: op = ALU_OP_LB;  3'd1: op = ALU_OP_LH;  3'd2: op = ALU_OP_LW;
               3'd4: op = ALU_OP_LBU; 3'd5: op = ALU_OP_LHU;
               default: op = ALU_OP_NOP;
            endcase
         end
         7'b0100011: begin
            imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; use1 = 1'b1; use2 = 1'b1;
            case (f3)
               3'd0: op = ALU_OP_SB; 3'd1: op = ALU_OP_SH; 3'd2: op = ALU_OP_SW;
               default: op = ALU_OP_NOP;
            endcase
         end
         7'b0010011: begin
            imm = {{20{ins[31]}}, ins[31:20]}; use1 = 1'b1; used = 1'b1;
            case (f3)
               3'd0: op = ALU_OP_ADDI;  3'd2: op = ALU_OP_SLTI;  3'd3: op = ALU_OP_SLTIU;
               3'd4: op = ALU_OP_XORI;  3'd6: op = ALU_OP_ORI;   3'd7: op = ALU_OP_ANDI;
               3'd1: op = (f7 == 7'b0000000) ? ALU_OP_SLLI : ALU_OP_NOP;
               default: op = (f7 == 7'b0000000) ? ALU_OP_SRLI :
                             (f7 == 7'b0100000) ? ALU_OP_SRAI : ALU_OP_NOP;
            endcase
         end
         7'b0110011: begin
            use1 = 1'b1; use2 = 1'b1; used = 1'b1;
            case ({f7, f3})
               10'b0000000_000: op = ALU_OP_ADD;    10'b0100000_000: op = ALU_OP_SUB;
               10'b0000000_001: op = ALU_OP_SLL;    10'b0000000_010: op = ALU_OP_SLT;
               10'b0000000_011: op = ALU_OP_SLTU;   10'b0000000_100: op = ALU_OP_XOR;
               10'b0000000_101: op = ALU_OP_SRL;    10'b0100000_101: op = ALU_OP_SRA;
               10'b0000000_110: op = ALU_OP_OR;     10'b0000000_111: op = ALU_OP_AND;
               10'b0000001_000: op = ALU_OP_MUL;    10'b0000001_001: op = ALU_OP_MULH;
               10'b0000001_010: op = ALU_OP_MULHSU; 10'b0000001_011: op = ALU_OP_MULHU;
               10'b0000001_100: op = ALU_OP_DIV;    10'b0000001_101: op = ALU_OP_DIVU;
               10'b0000001_110: op = ALU_OP_REM;    10'b0000001_111: op = ALU_OP_REMU;
               default:         op = ALU_OP_NOP;
            endcase
         end
         7'b0001111: begin
            imm = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd0) op = ALU_OP_FENCE;
         end
         7'b1110011: begin
            imm = {{20{ins[31]}}, ins[31:20]};
            if (ins[31:7] == 25'd0)                op = ALU_OP_ECALL;
            else if (ins[31:7] == {12'd1, 13'd0})  op = ALU_OP_EBREAK;
         end
         default: op = ALU_OP_NOP;
      endcase
      ill         = (op == ALU_OP_NOP);
      pkt.pc      = pc;
      pkt.alu_op  = op;
      pkt.imm32   = ill ? '0 : imm;
      pkt.rs1_sel = (use1 && !ill) ? ins[19:15] : 5'd0;
      pkt.rs2_sel = (use2 && !ill) ? ins[24:20] : 5'd0;
      pkt.rd_sel  = (used && !ill) ? ins[11:7]  : 5'd0;
   endfunction

   logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [PW:0]        r_count;
   rv32_instr_packet_t r_mem [DEPTH];

   rv32_instr_packet_t w_dec [LANES];
   logic [LANES-1:0]   w_dec_ill, w_push, w_pop, w_out_valid;
   logic [PW:0]        w_n_push, w_n_pop;
   logic               w_in_ready, w_run_in, w_run_out;

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         f_decode(i_in_packet[l*IFW +: 32], i_in_packet[l*IFW+32 +: 32], w_dec[l], w_dec_ill[l]);
      end
   end

   // Non-prefix valid/ready patterns collapse to their lane-0 prefix via the running AND.
   always_comb begin
      w_in_ready = !i_rst && (int'(r_count) + LANES <= DEPTH);
      w_run_in   = 1'b1;
      w_run_out  = 1'b1;
      w_n_push   = '0;
      w_n_pop    = '0;
      for (int l = 0; l < LANES; l++) begin
         w_out_valid[l] = (int'(r_count) > l);
         w_run_in       = w_run_in & i_in_valid[l];
         w_run_out      = w_run_out & i_out_ready[l] & w_out_valid[l];
         w_push[l]      = w_run_in & w_in_ready & !i_flush;
         w_pop[l]       = w_run_out;
         w_n_push       = w_n_push + {{PW{1'b0}}, w_push[l]};
         w_n_pop        = w_n_pop + {{PW{1'b0}}, w_pop[l]};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_count  <= r_count + w_n_push - w_n_pop;
         r_wr_ptr <= r_wr_ptr + w_n_push[PW-1:0];
         r_rd_ptr <= r_rd_ptr + w_n_pop[PW-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (w_push[l]) r_mem[r_wr_ptr + PW'(l)] <= w_dec[l];
      end
   end

   always_comb begin
      o_out_packet = '0;
      for (int l = 0; l < LANES; l++) begin
         if (w_out_valid[l]) o_out_packet[l*PKW +: PKW] = r_mem[r_rd_ptr + PW'(l)];
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = w_out_valid;

`ifdef DEC_QUEUE_ILLEGAL_EN
   logic r_ill [DEPTH];

   always_ff @(posedge i_clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (w_push[l]) r_ill[r_wr_ptr + PW'(l)] <= w_dec_ill[l];
      end
   end

   always_comb begin
      o_out_illegal = '0;
      for (int l = 0; l < LANES; l++) begin
         o_out_illegal[l] = w_out_valid[l] & r_ill[r_rd_ptr + PW'(l)];
      end
   end
`else
   logic w_unused_ill;
   assign w_unused_ill  = ^w_dec_ill;
   assign o_out_illegal = '0;
`endif
endmodule

// File: tb/tb_dec_queue.sv
// Scoreboard bench for dec_queue: a table of hand-decoded instructions feeds a queue model.
module tb_dec_queue;
   import dec_queue_pkg::*;

   localparam int LANES = 2;
   localparam int DEPTH = 8;
   localparam int IFW   = $bits(rv32_if_packet_t);
   localparam int PKW   = $bits(rv32_instr_packet_t);
   localparam int NT    = 15;
`ifdef DEC_QUEUE_ILLEGAL_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   typedef struct packed {
      rv32_instr_packet_t pkt;
      logic               ill;
   } sb_t;

   logic                   clk = 1'b0;
   logic                   rst, flush;
   logic [LANES-1:0]       in_valid, out_ready, out_valid, out_illegal;
   logic [LANES*IFW-1:0]   in_packet;
   logic [LANES*PKW-1:0]   out_packet;
   logic                   in_ready;

   dec_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
      .i_in_valid(in_valid), .i_in_packet(in_packet), .o_in_ready(in_ready),
      .o_out_valid(out_valid), .o_out_packet(out_packet),
      .o_out_illegal(out_illegal), .i_out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int                 n_err = 0, n_chk = 0, seq = 0;
   bit                 chk_en = 1'b0;
   sb_t                q[$];
   logic [31:0]        t_ins [NT];
   rv32_instr_packet_t t_exp [NT];
   logic               t_ill [NT];

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tbl(input int i, input logic [31:0] ins, input logic [31:0] imm,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input alu_op_t op, input logic il);
      t_ins[i] = ins;
      t_exp[i] = '{pc: 32'd0, imm32: imm, rs1_sel: r1, rs2_sel: r2, rd_sel: rd, alu_op: op};
      t_ill[i] = il;
   endtask

   // One cycle: drive at negedge, check outputs against the model, then advance the model.
   task automatic cyc(input logic rv, input logic fv, input logic [1:0] iv, input logic [1:0] orv,
                      input int k0, input int k1);
      sb_t         e [LANES];
      int          k, nv, np;
      logic        rdy_exp;
      logic [1:0]  vexp;
      logic [31:0] pc_v;
      @(negedge clk);
      rst = rv; flush = fv; in_valid = iv; out_ready = orv;
      for (int l = 0; l < LANES; l++) begin
         k = (l == 0) ? k0 : k1;
         if (k < 0) k = $urandom_range(0, NT-1);
         pc_v = 32'h1000 + 32'(4 * seq);
         seq++;
         in_packet[l*IFW +: IFW] = {pc_v, t_ins[k]};
         e[l].pkt    = t_exp[k];
         e[l].pkt.pc = pc_v;
         e[l].ill    = ILL_EN ? t_ill[k] : 1'b0;
      end
      #1;
      nv      = (q.size() < LANES) ? q.size() : LANES;
      rdy_exp = !rv && (q.size() + LANES <= DEPTH);
      vexp    = (nv == 0) ? 2'b00 : (nv == 1) ? 2'b01 : 2'b11;
      if (chk_en) begin
         chk("in_ready", 128'(in_ready), 128'(rdy_exp));
         chk("out_valid", 128'(out_valid), 128'(vexp));
         for (int l = 0; l < LANES; l++) begin
            if (l < nv) begin
               chk("out_packet", 128'(out_packet[l*PKW +: PKW]), 128'(q[l].pkt));
               chk("out_illegal", 128'(out_illegal[l]), 128'(q[l].ill));
            end else begin
               chk("out_packet_idle", 128'(out_packet[l*PKW +: PKW]), 128'd0);
               chk("out_illegal_idle", 128'(out_illegal[l]), 128'd0);
            end
         end
      end
      if (rv || fv) begin
         q.delete();
      end else begin
         np = 0;
         while (np < nv && orv[np]) np++;
         repeat (np) void'(q.pop_front());
         if (rdy_exp) begin
            if (iv[0]) q.push_back(e[0]);
            if (iv[0] && iv[1]) q.push_back(e[1]);
         end
      end
   endtask

   initial begin
      tbl(0,  32'hFFF00093, 32'hFFFFFFFF, 5'd0,  5'd0,  5'd1,  ALU_OP_ADDI,  1'b0);
      tbl(1,  32'h0080006F, 32'h00000008, 5'd0,  5'd0,  5'd0,  ALU_OP_JAL,   1'b0);
      tbl(2,  32'h40208133, 32'h00000000, 5'd1,  5'd2,  5'd2,  ALU_OP_SUB,   1'b0);
      tbl(3,  32'hFFFFFFFF, 32'h00000000, 5'd0,  5'd0,  5'd0,  ALU_OP_NOP,   1'b1);
      tbl(4,  32'h123450B7, 32'h12345000, 5'd0,  5'd0,  5'd1,  ALU_OP_LUI,   1'b0);
      tbl(5,  32'hFE208EE3, 32'hFFFFFFFC, 5'd1,  5'd2,  5'd0,  ALU_OP_BEQ,   1'b0);
      tbl(6,  32'h00532423, 32'h00000008, 5'd6,  5'd5,  5'd0,  ALU_OP_SW,    1'b0);
      tbl(7,  32'hFF822183, 32'hFFFFFFF8, 5'd4,  5'd0,  5'd3,  ALU_OP_LW,    1'b0);
      tbl(8,  32'h40345393, 32'h00000403, 5'd8,  5'd0,  5'd7,  ALU_OP_SRAI,  1'b0);
      tbl(9,  32'h40341393, 32'h00000000, 5'd0,  5'd0,  5'd0,  ALU_OP_NOP,   1'b1);
      tbl(10, 32'h02C58533, 32'h00000000, 5'd11, 5'd12, 5'd10, ALU_OP_MUL,   1'b0);
      tbl(11, 32'hFFFFF297, 32'hFFFFF000, 5'd0,  5'd0,  5'd5,  ALU_OP_AUIPC, 1'b0);
      tbl(12, 32'h010100E7, 32'h00000010, 5'd2,  5'd0,  5'd1,  ALU_OP_JALR,  1'b0);
      tbl(13, 32'h025251B3, 32'h00000000, 5'd4,  5'd5,  5'd3,  ALU_OP_DIVU,  1'b0);
      tbl(14, 32'h40209133, 32'h00000000, 5'd0,  5'd0,  5'd0,  ALU_OP_NOP,   1'b1);

      rst = 1'b1; flush = 1'b0; in_valid = '0; out_ready = '0; in_packet = '0;
      cyc(1, 0, 2'b00, 2'b00, -1, -1);
      chk_en = 1'b1;
      cyc(1, 0, 2'b11, 2'b11, -1, -1);
      // addi on lane 0, then jal+sub together
      cyc(0, 0, 2'b01, 2'b00, 0, -1);
      cyc(0, 0, 2'b00, 2'b00, -1, -1);
      cyc(0, 0, 2'b11, 2'b01, 1, 2);
      cyc(0, 0, 2'b00, 2'b11, -1, -1);
      // non-prefix valid, then fill one lane at a time until in_ready drops
      cyc(0, 0, 2'b10, 2'b00, -1, -1);
      repeat (9) cyc(0, 0, 2'b01, 2'b00, -1, -1);
      cyc(0, 0, 2'b11, 2'b11, -1, -1);
      cyc(0, 0, 2'b11, 2'b00, -1, -1);
      cyc(0, 0, 2'b00, 2'b10, -1, -1);
      repeat (5) cyc(0, 0, 2'b00, 2'b11, -1, -1);
      // illegal encodings
      cyc(0, 0, 2'b11, 2'b00, 3, 9);
      cyc(0, 0, 2'b11, 2'b11, 14, 8);
      repeat (2) cyc(0, 0, 2'b00, 2'b11, -1, -1);
      // flush with five entries while pushing and popping
      cyc(0, 0, 2'b11, 2'b00, -1, -1);
      cyc(0, 0, 2'b11, 2'b00, -1, -1);
      cyc(0, 0, 2'b01, 2'b00, -1, -1);
      cyc(0, 1, 2'b11, 2'b11, -1, -1);
      cyc(0, 0, 2'b00, 2'b00, -1, -1);
      // reset with three entries
      cyc(0, 0, 2'b11, 2'b00, -1, -1);
      cyc(0, 0, 2'b01, 2'b00, -1, -1);
      cyc(1, 0, 2'b11, 2'b11, -1, -1);
      cyc(1, 0, 2'b00, 2'b00, -1, -1);
      cyc(0, 0, 2'b00, 2'b00, -1, -1);
      // random traffic with occasional flush, then drain
      repeat (400) begin
         cyc(0, ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), -1, -1);
      end
      repeat (6) cyc(0, 0, 2'b00, 2'b11, -1, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/dec_queue.md
DEC_QUEUE -- requirements
Module: dec_queue

Interface
REQ-001 Parameter LANES, default 2, is the number of decode lanes per cycle; legal values are 1..4.
REQ-002 Parameter DEPTH, default 8, is the number of decoded-packet entries; it SHALL be a power of two with DEPTH >= 2*LANES.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 flush  in  1  discard all buffered entries and this cycle's input.
REQ-006 in_valid  in  LANES  per-lane instruction valid, lane 0 first.
REQ-007 in_packet  in  LANES x rv32_if_packet_t  fetched instruction and pc per lane.
REQ-008 in_ready  out  1  all LANES lanes can be accepted this cycle.
REQ-009 out_valid  out  LANES  lane l holds the (l+1)-th oldest entry.
REQ-010 out_packet  out  LANES x rv32_instr_packet_t  decoded packet per lane.
REQ-011 out_illegal  out  LANES  per-lane illegal-instruction flag.
REQ-012 out_ready  in  LANES  per-lane consume strobe from the consumer.

Function
REQ-013 Decode SHALL cover RV32I plus RV32M with the team's opcode and alu_op encodings; pc SHALL pass through unchanged.
REQ-014 Immediates: I-type sign-extends instr[31:20]; S-type sign-extends {instr[31:25],instr[11:7]}; B-type sign-extends {instr[31],instr[7],instr[30:25],instr[11:8],0}; J-type sign-extends {instr[31],instr[19:12],instr[20],instr[30:21],0}; U-type is {instr[31:12],12'b0}.
REQ-015 rs1_sel, rs2_sel and rd_sel SHALL be zero for any field that the instruction format does not use.
REQ-016 An unknown opcode, or an undefined funct3/funct7 combination, SHALL produce alu_op=ALU_OP_NOP, zero register selects and illegal=1.
REQ-017 SRLI/SRAI and SLLI with funct7 other than 0000000 or 0100000 (SRAI only) are illegal.
REQ-018 in_valid and out_ready SHALL be contiguous from lane 0; a non-prefix pattern SHALL be treated as its longest lane-0 prefix.
REQ-019 in_ready = (free entries >= LANES) and not rst; it SHALL depend only on state, never on in_valid.
REQ-020 Push: when in_ready and in_valid[l], lane l is decoded and written in lane order at wr_ptr+l; wr_ptr advances by the number of lanes pushed.
REQ-021 Pop: lane l pops when out_valid[l] and out_ready[l]; rd_ptr advances by the popped count.
REQ-022 Latency: an entry pushed at edge N SHALL be visible on out_* after edge N; there is no combinational input-to-output path.
REQ-023 out_valid[l] = (count > l); out_packet and out_illegal for invalid lanes SHALL be zero.
REQ-024 On a simultaneous push and pop: count_next = count + pushed - popped; a full buffer SHALL accept pushes in the same cycle it frees space only on the following cycle.
REQ-025 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-026 flush SHALL set count and both pointers to 0 at the edge; pushes and pops in that cycle are ignored; out_valid is 0 the next cycle.

Reset
REQ-027 While rst is high at an edge: count=0, wr_ptr=0, rd_ptr=0; out_valid=0, in_ready=0 and out_packet/out_illegal=0 in the following cycle.
REQ-028 A reset mid-operation SHALL discard all entries; the storage array needs no reset.
REQ-029 rst SHALL take priority over flush, and flush over push/pop.

Configuration
REQ-030 With macro DEC_QUEUE_ILLEGAL_EN defined, illegal detection SHALL be computed and one flag bit SHALL be stored per entry.
REQ-031 With DEC_QUEUE_ILLEGAL_EN undefined, out_illegal SHALL be tied to 0, no flag storage is built, and decode results are otherwise identical.

Verification
REQ-032 Reset then push addi x1,x0,-1 (0xFFF00093) on lane 0 -> next cycle out_valid=01, rd_sel=1, rs1_sel=0, imm32=0xFFFFFFFF, alu_op=ALU_OP_ADDI.
REQ-033 Push 0x0080006F (jal x0,+8) and 0x40208133 (sub x2,x1,x2) together -> lane0 imm32=8, alu_op=ALU_OP_JAL; lane1 alu_op=ALU_OP_SUB, rs1=1, rs2=2, rd=2.
REQ-034 Fill DEPTH=8 with out_ready=0 -> in_ready drops at count=7 (LANES=2); pop 2 -> in_ready rises the next cycle; order preserved across wrap-around.
REQ-035 Push 0xFFFFFFFF with DEC_QUEUE_ILLEGAL_EN -> out_illegal=1, alu_op=NOP; without the macro -> out_illegal=0.
REQ-036 Assert flush with count=5 while pushing and popping -> count=0 next cycle, out_valid=0, pushed data is not visible.
REQ-037 Assert rst with count=3 -> out_valid=0 and in_ready=0 the next cycle; in_ready=1 once rst is released.
